rainbow_sequencer: RTL

//  Upstream controller for three PWM channel instances (R, G, B) in the RainbowRGB design.

---
 rtl/rainbow_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rainbow_sequencer.sv
// RainbowRGB colour-wheel sequencer: steps six hue phases on rising STT edges of the active PWM channel.
// Optional watchdog forced-advance is compiled in when RAINBOW_WATCHDOG_EN is defined.
module rainbow_sequencer #(
    parameter int unsigned   TW          = 25,
    parameter logic [TW-1:0] TIMEOUT_CYC = 25'd16100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       STT_R,
    input  logic       STT_G,
    input  logic       STT_B,
    output logic       FLAG_R,
    output logic       FLAG_G,
    output logic       FLAG_B,
    output logic [2:0] PHASE,
    output logic       ADV,
    output logic       WD_ERR
);

    typedef enum logic [2:0] {
        P0 = 3'd0,
        P1 = 3'd1,
        P2 = 3'd2,
        P3 = 3'd3,
        P4 = 3'd4,
        P5 = 3'd5
    } phase_t;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    phase_t     phase_reg;
    phase_t     phase_next;
    logic       flag_r_reg;
    logic       flag_g_reg;
    logic       flag_b_reg;
    logic       adv_reg;
    logic [2:0] stt_in;
    logic [2:0] evt;
    logic       active_evt;
    logic       advance;

    assign stt_in = {STT_B, STT_G, STT_R};

    // History resets high so an STT already asserted at reset is not seen as an edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            logic stt_q_reg;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    stt_q_reg <= 1'b1;
                end else begin
                    stt_q_reg <= stt_in[gi];
                end
            end
            assign evt[gi] = stt_in[gi] & ~stt_q_reg;
        end
    endgenerate

    always_comb begin
        active_evt = 1'b0;
        case (phase_reg)
            P0, P3:  active_evt = evt[CH_G];
            P1, P4:  active_evt = evt[CH_R];
            P2, P5:  active_evt = evt[CH_B];
            default: active_evt = 1'b0;
        endcase
    end

    always_comb begin
        phase_next = (phase_reg == P5) ? P0 : phase_t'(phase_reg + 3'd1);
    end

`ifdef RAINBOW_WATCHDOG_EN
    logic [TW-1:0] wd_count_reg;
    logic          wd_err_reg;
    logic          timeout;

    assign timeout = (wd_count_reg == TIMEOUT_CYC - 1'b1);
    assign advance = EN & (active_evt | timeout);

    // A real event at the timeout cycle wins: one advance, no error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_count_reg <= '0;
            wd_err_reg   <= 1'b0;
        end else if (EN) begin
            if (advance) begin
                wd_count_reg <= '0;
                if (!active_evt) begin
                    wd_err_reg <= 1'b1;
                end
            end else begin
                wd_count_reg <= wd_count_reg + 1'b1;
            end
        end
    end

    assign WD_ERR = wd_err_reg;
`else
    assign advance = EN & active_evt;
    // Evaluates to 0; keeps the timeout parameter referenced in the watchdog-less build.
    assign WD_ERR  = 1'b0 & (|TIMEOUT_CYC);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_reg  <= P0;
            flag_r_reg <= 1'b1;
            flag_g_reg <= 1'b1;
            flag_b_reg <= 1'b0;
            adv_reg    <= 1'b0;
        end else begin
            adv_reg <= advance;
            if (advance) begin
                phase_reg <= phase_next;
                // Only the incoming phase's channel receives its new direction.
                case (phase_next)
                    P0:      flag_g_reg <= 1'b1;
                    P1:      flag_r_reg <= 1'b0;
                    P2:      flag_b_reg <= 1'b1;
                    P3:      flag_g_reg <= 1'b0;
                    P4:      flag_r_reg <= 1'b1;
                    P5:      flag_b_reg <= 1'b0;
                    default: flag_g_reg <= flag_g_reg;
                endcase
            end
        end
    end

    assign PHASE  = phase_reg;
    assign FLAG_R = flag_r_reg;
    assign FLAG_G = flag_g_reg;
    assign FLAG_B = flag_b_reg;
    assign ADV    = adv_reg;

endmodule
